// File: rtl/psum_packer.sv
// psum_packer: accumulates i_accLen partial sums per lane, requantizes each
// result (shift, optional rounding, clamp) to the lane width of the current
// mode and packs lanes LSB-first into DWD-bit words behind a two-stage
// (pack register -> output register) pipeline.
// Optional feature macro: PSUMPACK_ROUND_EN (round-half-up before the shift).
//
// state | meaning
// RUN   | pack register open, sums accepted
// FULL  | pack register holds a closed word, waiting on the output register

`ifndef CLK_INPUT
`define CLK_INPUT input logic
`endif

package psum_packer_pkg;
  typedef enum logic [2:0] {
    XNOR = 3'd0,
    M1   = 3'd1,
    M2   = 3'd2,
    M4   = 3'd3,
    M8   = 3'd4
  } au_mode_e;

  // iNumT: 1 = signed output lanes, 0 = unsigned output lanes
  typedef struct packed {
    au_mode_e mode;
    logic     iNumT;
  } AuCtl;
endpackage

module psum_packer
  import psum_packer_pkg::*;
#(
  parameter int DWD     = 16,
  parameter int ASUMDWD = 18,
  parameter int ACCWD   = 24
) (
  `CLK_INPUT                      i_clk,
  `CLK_INPUT                      i_rst,
  input  AuCtl                    i_ctl,
  input  logic [7:0]              i_accLen,
  input  logic [4:0]              i_shift,
  input  logic                    i_sum_val,
  output logic                    i_sum_rdy,
  input  logic signed [ASUMDWD-1:0] i_sum,
  input  logic                    i_flush,
  output logic                    o_pix_val,
  input  logic                    i_pix_rdy,
  output logic [DWD-1:0]          o_pix,
  output logic                    o_pix_last
);

  typedef enum logic {RUN = 1'b0, FULL = 1'b1} state_e;

  localparam int LCW = $clog2(DWD) + 1;
  localparam int AW1 = ACCWD + 1;

  state_e                   r_state, w_state_nxt;
  logic                     r_flush_pend, w_flush_pend_nxt;
  logic signed [ACCWD-1:0]  r_acc, w_acc_nxt, w_total;
  logic [7:0]               r_sum_cnt, w_sum_cnt_nxt;
  logic [LCW-1:0]           r_lane_cnt, w_lane_cnt_nxt, w_lanes;
  logic [DWD-1:0]           r_pack, w_pack_nxt;
  logic                     r_pack_last, w_pack_last_nxt;
  au_mode_e                 r_mode, w_mode;
  logic                     r_sgn, w_sgn;
  logic [7:0]               r_acc_len, w_acc_len;
  logic [4:0]               r_shift, w_shift;
  logic [DWD-1:0]           r_pix;
  logic                     r_pix_val, r_pix_last;
  logic                     w_sum_fire, w_first, w_capture, w_xfer;
  int                       w_lw;

  function automatic int lane_w(input au_mode_e mode);
    case (mode)
      M2:      return 2;
      M4:      return 4;
      M8:      return 8;
      default: return 1;
    endcase
  endfunction

  // Shift (optionally rounded), then clamp to the lane range; XNOR binarizes on sign.
  function automatic logic [7:0] requant(input logic signed [ACCWD-1:0] val,
                                         input au_mode_e mode,
                                         input logic sgn,
                                         input logic [4:0] sh);
    logic signed [AW1-1:0] v, lo, hi;
    int lw;
    lw = lane_w(mode);
    v  = AW1'(val);
`ifdef PSUMPACK_ROUND_EN
    if (sh != 5'd0) v = v + (AW1'(1) <<< (sh - 5'd1));
`endif
    v = v >>> sh;
    if (sgn && (mode != M1)) begin
      hi = AW1'((1 << (lw - 1)) - 1);
      lo = -hi - AW1'(1);
    end else begin
      hi = AW1'((1 << lw) - 1);
      lo = '0;
    end
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    if (mode == XNOR) return {7'd0, ~val[ACCWD-1]};
    return v[7:0] & 8'((1 << lw) - 1);
  endfunction

  assign i_sum_rdy  = (r_state == RUN) && !r_flush_pend;
  assign w_sum_fire = i_sum_val && i_sum_rdy;
  assign w_first    = (r_lane_cnt == '0) && (r_sum_cnt == '0);
  assign w_capture  = w_sum_fire && w_first;
  assign w_xfer     = (r_state == FULL) && (!r_pix_val || i_pix_rdy);

  // Config seen by the first sum of a word comes straight from the inputs
  assign w_mode    = w_capture ? i_ctl.mode  : r_mode;
  assign w_sgn     = w_capture ? i_ctl.iNumT : r_sgn;
  assign w_shift   = w_capture ? i_shift     : r_shift;
  assign w_acc_len = w_capture ? ((i_accLen == 8'd0) ? 8'd1 : i_accLen) : r_acc_len;
  assign w_lw      = lane_w(w_mode);
  assign w_lanes   = LCW'(DWD / w_lw);

  // Next-state: accumulate, close lanes, apply flush after any same-cycle sum
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    w_acc_nxt        = r_acc;
    w_sum_cnt_nxt    = r_sum_cnt;
    w_lane_cnt_nxt   = r_lane_cnt;
    w_pack_nxt       = r_pack;
    w_pack_last_nxt  = r_pack_last;
    w_total          = r_acc + ACCWD'(i_sum);
    case (r_state)
      RUN: begin
        if (w_sum_fire) begin
          if (r_sum_cnt + 8'd1 == w_acc_len) begin
            w_pack_nxt = w_pack_nxt |
                         (DWD'(requant(w_total, w_mode, w_sgn, w_shift)) << (int'(r_lane_cnt) * w_lw));
            w_acc_nxt      = '0;
            w_sum_cnt_nxt  = '0;
            w_lane_cnt_nxt = r_lane_cnt + LCW'(1);
          end else begin
            w_acc_nxt     = w_total;
            w_sum_cnt_nxt = r_sum_cnt + 8'd1;
          end
        end
        w_flush_pend_nxt = 1'b0;
        if ((i_flush || r_flush_pend) && ((w_lane_cnt_nxt != '0) || (w_sum_cnt_nxt != '0))) begin
          // Partial lane goes in; untouched upper lanes are already zero
          if (w_sum_cnt_nxt != '0)
            w_pack_nxt = w_pack_nxt |
                         (DWD'(requant(w_acc_nxt, w_mode, w_sgn, w_shift)) << (int'(w_lane_cnt_nxt) * w_lw));
          w_pack_last_nxt = 1'b1;
          w_state_nxt     = FULL;
          w_acc_nxt       = '0;
          w_sum_cnt_nxt   = '0;
          w_lane_cnt_nxt  = '0;
        end else if (w_lane_cnt_nxt == w_lanes) begin
          w_state_nxt    = FULL;
          w_lane_cnt_nxt = '0;
        end
      end
      FULL: begin
        if (i_flush) w_flush_pend_nxt = 1'b1;
        if (w_xfer) begin
          w_state_nxt     = RUN;
          w_pack_nxt      = '0;
          w_pack_last_nxt = 1'b0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State, accumulator, counters and pack register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_sum_cnt    <= '0;
      r_lane_cnt   <= '0;
      r_pack       <= '0;
      r_pack_last  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_acc        <= w_acc_nxt;
      r_sum_cnt    <= w_sum_cnt_nxt;
      r_lane_cnt   <= w_lane_cnt_nxt;
      r_pack       <= w_pack_nxt;
      r_pack_last  <= w_pack_last_nxt;
    end
  end

  // Per-word configuration, latched on the first accepted sum
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode    <= M8;
      r_sgn     <= 1'b0;
      r_acc_len <= 8'd1;
      r_shift   <= '0;
    end else if (w_capture) begin
      r_mode    <= w_mode;
      r_sgn     <= w_sgn;
      r_acc_len <= w_acc_len;
      r_shift   <= w_shift;
    end
  end

  // Output register: loads a closed word, holds it until accepted downstream
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix      <= '0;
      r_pix_val  <= 1'b0;
      r_pix_last <= 1'b0;
    end else if (w_xfer) begin
      r_pix      <= r_pack;
      r_pix_val  <= 1'b1;
      r_pix_last <= r_pack_last;
    end else if (i_pix_rdy) begin
      r_pix_val  <= 1'b0;
    end
  end

  assign o_pix      = r_pix;
  assign o_pix_val  = r_pix_val;
  assign o_pix_last = r_pix_last;

endmodule

// File: tb/tb_psum_packer.sv
// Directed bench for psum_packer: table of single-word vectors plus
// hand-written backpressure and mid-word reset sequences.
module tb_psum_packer;
  import psum_packer_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  AuCtl               i_ctl;
  logic [7:0]         i_accLen;
  logic [4:0]         i_shift;
  logic               i_sum_val;
  logic               i_sum_rdy;
  logic signed [17:0] i_sum;
  logic               i_flush;
  logic               o_pix_val;
  logic               i_pix_rdy;
  logic [15:0]        o_pix;
  logic               o_pix_last;

  psum_packer #(.DWD(16), .ASUMDWD(18), .ACCWD(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ctl(i_ctl), .i_accLen(i_accLen),
    .i_shift(i_shift), .i_sum_val(i_sum_val), .i_sum_rdy(i_sum_rdy),
    .i_sum(i_sum), .i_flush(i_flush), .o_pix_val(o_pix_val),
    .i_pix_rdy(i_pix_rdy), .o_pix(o_pix), .o_pix_last(o_pix_last)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic        mon_en = 1'b0;
  logic [15:0] q[$];
  always @(negedge i_clk) if (mon_en && o_pix_val && i_pix_rdy) q.push_back(o_pix);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Present one sum, wait (bounded) for ready, complete the handshake.
  task automatic send_sum(input logic signed [17:0] s, input logic fl, output int hs);
    int b;
    b = 0;
    i_sum_val = 1'b1;
    i_sum     = s;
    while (!i_sum_rdy && b < 50) begin
      @(posedge i_clk); #1;
      b++;
    end
    if (!i_sum_rdy) chk("sum_rdy_timeout", 32'd0, 32'd1);
    i_flush = fl;
    @(posedge i_clk); #1;
    hs        = cyc;
    i_sum_val = 1'b0;
    i_flush   = 1'b0;
  endtask

  // Wait for the packed word, check latency/content, let it drain.
  task automatic wait_pix(input int hs, input string nm, input logic [15:0] ep, input logic el);
    int b;
    b = 0;
    while (!o_pix_val && b < 20) begin
      @(posedge i_clk); #1;
      b++;
    end
    chk({nm, "_lat"}, cyc - hs, 32'd1);
    chk({nm, "_pix"}, {16'd0, o_pix}, {16'd0, ep});
    chk({nm, "_last"}, {31'd0, o_pix_last}, {31'd0, el});
    @(posedge i_clk); #1;
    chk({nm, "_drain"}, {31'd0, o_pix_val}, 32'd0);
    chk({nm, "_rdy"}, {31'd0, i_sum_rdy}, 32'd1);
  endtask

  typedef struct {
    au_mode_e          mode;
    logic              sgn;
    logic [7:0]        acc_len;
    logic [4:0]        shift;
    int                nsum;
    logic [15:0][17:0] sums;
    int                fl;      // 0 none, 1 flush after sums, 2 flush with last sum
    logic [15:0]       exp_t;
    logic [15:0]       exp_r;
    logic              last;
  } vec_t;

  vec_t vt[8];

  initial begin
    int hs;
    logic [15:0] expv;

    // ---- vector table ----
    vt[0].mode = M8;   vt[0].sgn = 1; vt[0].acc_len = 1; vt[0].shift = 0; vt[0].nsum = 2;
    vt[0].fl = 0; vt[0].exp_t = 16'h8064; vt[0].exp_r = 16'h8064; vt[0].last = 0;
    vt[0].sums[0] = 18'sd100; vt[0].sums[1] = -18'sd200;

    vt[1].mode = M4;   vt[1].sgn = 0; vt[1].acc_len = 2; vt[1].shift = 1; vt[1].nsum = 8;
    vt[1].fl = 0; vt[1].exp_t = 16'hF0A3; vt[1].exp_r = 16'hF0A4; vt[1].last = 0;
    vt[1].sums[0] = 18'sd3;  vt[1].sums[1] = 18'sd4;  vt[1].sums[2] = 18'sd10; vt[1].sums[3] = 18'sd10;
    vt[1].sums[4] = -18'sd5; vt[1].sums[5] = 18'sd1;  vt[1].sums[6] = 18'sd40; vt[1].sums[7] = 18'sd0;

    vt[2].mode = XNOR; vt[2].sgn = 1; vt[2].acc_len = 1; vt[2].shift = 0; vt[2].nsum = 16;
    vt[2].fl = 0; vt[2].exp_t = 16'h5555; vt[2].exp_r = 16'h5555; vt[2].last = 0;
    for (int i = 0; i < 16; i++) vt[2].sums[i] = (i % 2 == 0) ? 18'sd0 : -18'sd2;

    vt[3].mode = M2;   vt[3].sgn = 1; vt[3].acc_len = 1; vt[3].shift = 0; vt[3].nsum = 3;
    vt[3].fl = 1; vt[3].exp_t = 16'h001D; vt[3].exp_r = 16'h001D; vt[3].last = 1;
    vt[3].sums[0] = 18'sd1; vt[3].sums[1] = -18'sd1; vt[3].sums[2] = 18'sd5;

    vt[4].mode = M1;   vt[4].sgn = 1; vt[4].acc_len = 3; vt[4].shift = 0; vt[4].nsum = 7;
    vt[4].fl = 2; vt[4].exp_t = 16'h0006; vt[4].exp_r = 16'h0006; vt[4].last = 1;
    vt[4].sums[0] = 18'sd1; vt[4].sums[1] = 18'sd1; vt[4].sums[2] = -18'sd3;
    vt[4].sums[3] = 18'sd0; vt[4].sums[4] = 18'sd0; vt[4].sums[5] = 18'sd2; vt[4].sums[6] = 18'sd5;

    vt[5].mode = M8;   vt[5].sgn = 0; vt[5].acc_len = 0; vt[5].shift = 2; vt[5].nsum = 2;
    vt[5].fl = 0; vt[5].exp_t = 16'h00FF; vt[5].exp_r = 16'h00FF; vt[5].last = 0;
    vt[5].sums[0] = 18'sd1023; vt[5].sums[1] = -18'sd4;

    vt[6].mode = M4;   vt[6].sgn = 1; vt[6].acc_len = 1; vt[6].shift = 0; vt[6].nsum = 4;
    vt[6].fl = 0; vt[6].exp_t = 16'h8877; vt[6].exp_r = 16'h8877; vt[6].last = 0;
    vt[6].sums[0] = 18'sd7; vt[6].sums[1] = 18'sd8; vt[6].sums[2] = -18'sd8; vt[6].sums[3] = -18'sd9;

    vt[7].mode = M2;   vt[7].sgn = 0; vt[7].acc_len = 1; vt[7].shift = 3; vt[7].nsum = 4;
    vt[7].fl = 1; vt[7].exp_t = 16'h0009; vt[7].exp_r = 16'h001E; vt[7].last = 1;
    vt[7].sums[0] = 18'sd12; vt[7].sums[1] = 18'sd20; vt[7].sums[2] = 18'sd4; vt[7].sums[3] = -18'sd100000;

    // ---- reset ----
    i_ctl = '{mode: M8, iNumT: 1'b1};
    i_accLen = 8'd1; i_shift = 5'd0; i_sum_val = 1'b0; i_sum = '0;
    i_flush = 1'b0; i_pix_rdy = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    chk("rst_pix_val",  {31'd0, o_pix_val},  32'd0);
    chk("rst_pix",      {16'd0, o_pix},      32'd0);
    chk("rst_pix_last", {31'd0, o_pix_last}, 32'd0);
    chk("rst_sum_rdy",  {31'd0, i_sum_rdy},  32'd1);
    @(posedge i_clk); #1;

    // ---- table vectors; config is scrambled after the first sum to prove capture ----
    for (int v = 0; v < 8; v++) begin
      i_ctl.mode  = vt[v].mode;
      i_ctl.iNumT = vt[v].sgn;
      i_accLen    = vt[v].acc_len;
      i_shift     = vt[v].shift;
      for (int s = 0; s < vt[v].nsum; s++) begin
        send_sum(vt[v].sums[s], (vt[v].fl == 2) && (s == vt[v].nsum - 1), hs);
        if (s == 0) begin
          i_accLen    = 8'd5;
          i_shift     = 5'd3;
          i_ctl.mode  = M8;
          i_ctl.iNumT = ~i_ctl.iNumT;
        end
      end
      if (vt[v].fl == 1) begin
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        hs = cyc;
      end
`ifdef PSUMPACK_ROUND_EN
      expv = vt[v].exp_r;
`else
      expv = vt[v].exp_t;
`endif
      wait_pix(hs, $sformatf("vec%0d", v), expv, vt[v].last);
    end

    // ---- backpressure: M8, output stalled for 10 cycles ----
    i_ctl = '{mode: M8, iNumT: 1'b1};
    i_accLen = 8'd1; i_shift = 5'd0;
    i_pix_rdy = 1'b0;
    q.delete();
    mon_en = 1'b1;
    for (int s = 1; s <= 4; s++) send_sum(18'(s), 1'b0, hs);
    chk("bp_rdy_low", {31'd0, i_sum_rdy}, 32'd0);
    repeat (10) begin @(posedge i_clk); #1; end
    chk("bp_hold_val", {31'd0, o_pix_val}, 32'd1);
    chk("bp_hold_pix", {16'd0, o_pix}, 32'h0201);
    chk("bp_still_low", {31'd0, i_sum_rdy}, 32'd0);
    i_pix_rdy = 1'b1;
    for (int s = 5; s <= 8; s++) send_sum(18'(s), 1'b0, hs);
    for (int b = 0; b < 40 && q.size() < 4; b++) begin @(posedge i_clk); #1; end
    repeat (3) begin @(posedge i_clk); #1; end
    mon_en = 1'b0;
    chk("bp_count", q.size(), 32'd4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      chk($sformatf("bp_word%0d", i), {16'd0, q[i]}, {16'd0, 8'(2*i + 2), 8'(2*i + 1)});

    // ---- reset mid-word after 5 M2 lanes ----
    i_ctl = '{mode: M2, iNumT: 1'b1};
    i_accLen = 8'd1; i_shift = 5'd0;
    for (int s = 0; s < 5; s++) send_sum(18'sd1, 1'b0, hs);
    #1 i_rst = 1'b1;
    #1;
    chk("midrst_pix_val", {31'd0, o_pix_val}, 32'd0);
    chk("midrst_sum_rdy", {31'd0, i_sum_rdy}, 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    send_sum(-18'sd2, 1'b1, hs);
    wait_pix(hs, "midrst", 16'h0002, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
